// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: zeroes entries 1..DEPTH-1 after reset or on request.
//   state    | meaning
//   RF_CLEAR | writing 0 to entry clr_cnt each cycle; array not yet valid
//   RF_READY | array valid, normal writes accepted, clear_i honoured
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    output logic          ready_o,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state;
    logic [AW-1:0] clr_cnt;

    // Entry 0 is hardwired, so the sequence starts at 1 and stops at DEPTH-1
    // without the counter ever wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= RF_CLEAR;
            clr_cnt <= AW'(1);
            ready_o <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state   <= RF_READY;
                        ready_o <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                RF_READY: begin
                    if (clear_i) begin
                        state   <= RF_CLEAR;
                        clr_cnt <= AW'(1);
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= RF_CLEAR;
                    clr_cnt <= AW'(1);
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write priority, optional
// write-to-read bypass, hardwired zero entry and a hardware clear sequencer.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*AW-1:0]    wr_addr_i,
    input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
    input  logic                    clear_i,
    output logic                    ready_o,
    output logic                    busy_o
);

    logic             ready;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic [WIDTH-1:0] mem [DEPTH];

    regfile_clear_ctrl #(
        .DEPTH(DEPTH)
    ) u_clear_ctrl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .ready_o (ready),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign ready_o = ready;
    assign busy_o  = ~ready;

    // Ports are visited in ascending order so the highest-index enabled port
    // lands last and wins an address collision.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (ready) begin
            for (int q = 0; q < NUM_WR; q++) begin
                if (wr_en_i[q] && (wr_addr_i[q*AW +: AW] != '0)) begin
                    mem[wr_addr_i[q*AW +: AW]] <= wr_data_i[q*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rv;

        assign ra = rd_addr_i[p*AW +: AW];

        always_comb begin
            rv = mem[ra];
            if (BYPASS != 0) begin
                for (int q = 0; q < NUM_WR; q++) begin
                    if (wr_en_i[q] && (wr_addr_i[q*AW +: AW] == ra)) begin
                        rv = wr_data_i[q*WIDTH +: WIDTH];
                    end
                end
            end
            // Entry 0 is never stored, and nothing is valid mid-clear.
            if (!ready || (ra == '0)) begin
                rv = '0;
            end
        end

        assign rd_data_o[p*WIDTH +: WIDTH] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share all stimulus.
module tb_regfile_mp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  rd_addr_i;
    logic [9:0]  wr_addr_i;
    logic [1:0]  wr_en_i;
    logic [63:0] wr_data_i;
    logic        clear_i;
    logic [63:0] rd_bp;
    logic [63:0] rd_nb;
    logic        ready_bp, busy_bp, ready_nb, busy_nb;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    always #5 clk_i = ~clk_i;

    regfile_mp #(.BYPASS(1)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_bp),
        .wr_en_i  (wr_en_i),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .clear_i  (clear_i),
        .ready_o  (ready_bp),
        .busy_o   (busy_bp)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_nb),
        .wr_en_i  (wr_en_i),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .clear_i  (clear_i),
        .ready_o  (ready_nb),
        .busy_o   (busy_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr_i = {5'(31 - a), 5'(a)};
            #1;
            chk({tag, "_bp0"}, rd_bp[31:0], 32'h0);
            chk({tag, "_bp1"}, rd_bp[63:32], 32'h0);
            chk({tag, "_nb0"}, rd_nb[31:0], 32'h0);
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        clear_i   = 1'b0;
        wr_en_i   = 2'b00;
        wr_addr_i = '0;
        wr_data_i = '0;
        rd_addr_i = {5'd17, 5'd31};

        // 1: reset then idle
        tick();
        tick();
        chk("rst_ready", 32'(ready_bp), 32'h0);
        chk("rst_busy", 32'(busy_bp), 32'h1);
        rst_i = 1'b0;
        cnt = 0;
        while (!ready_bp && cnt < 100) begin
            chk("init_rd0", rd_bp[31:0], 32'h0);
            chk("init_rd1", rd_bp[63:32], 32'h0);
            tick();
            cnt++;
        end
        chk("init_len", 32'(cnt), 32'd31);
        chk("init_busy", 32'(busy_bp), 32'h0);
        chk("init_nb_ready", 32'(ready_nb), 32'h1);
        chk_all_zero("init_zero");

        // 2: basic write/read, same-cycle bypass vs stored
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd5};
        wr_data_i = {32'h0, 32'hDEADBEEF};
        rd_addr_i = {5'd6, 5'd5};
        #1;
        chk("wr_bp_same", rd_bp[31:0], 32'hDEADBEEF);
        chk("wr_nb_same", rd_nb[31:0], 32'h0);
        chk("wr_bp_other", rd_bp[63:32], 32'h0);
        tick();
        wr_en_i = 2'b00;
        #1;
        chk("wr_bp_next", rd_bp[31:0], 32'hDEADBEEF);
        chk("wr_nb_next", rd_nb[31:0], 32'hDEADBEEF);

        // 3: collision, port1 wins
        wr_en_i   = 2'b11;
        wr_addr_i = {5'd7, 5'd7};
        wr_data_i = {32'h22222222, 32'h11111111};
        rd_addr_i = {5'd5, 5'd7};
        #1;
        chk("col_bp_same", rd_bp[31:0], 32'h22222222);
        chk("col_nb_same", rd_nb[31:0], 32'h0);
        chk("col_other", rd_bp[63:32], 32'hDEADBEEF);
        tick();
        wr_en_i = 2'b00;
        #1;
        chk("col_bp_next", rd_bp[31:0], 32'h22222222);
        chk("col_nb_next", rd_nb[31:0], 32'h22222222);

        // 4: zero register
        wr_en_i   = 2'b11;
        wr_addr_i = {5'd0, 5'd0};
        wr_data_i = {32'hFFFFFFFF, 32'hFFFFFFFF};
        rd_addr_i = {5'd0, 5'd0};
        #1;
        chk("x0_bp_same0", rd_bp[31:0], 32'h0);
        chk("x0_bp_same1", rd_bp[63:32], 32'h0);
        tick();
        wr_en_i = 2'b00;
        #1;
        chk("x0_bp_next", rd_bp[31:0], 32'h0);
        chk("x0_nb_next", rd_nb[31:0], 32'h0);

        // 5: fill then clear request
        for (int i = 1; i < 32; i++) begin
            wr_en_i   = 2'b01;
            wr_addr_i = {5'd0, 5'(i)};
            wr_data_i = {32'h0, i * 32'h01010101};
            tick();
        end
        wr_en_i   = 2'b00;
        rd_addr_i = {5'd5, 5'd31};
        #1;
        chk("fill_x31", rd_nb[31:0], 32'h1F1F1F1F);
        chk("fill_x5", rd_nb[63:32], 32'h05050505);
        clear_i = 1'b1;
        tick();
        clear_i   = 1'b0;
        rd_addr_i = {5'd2, 5'd31};
        cnt = 0;
        while (busy_bp && cnt < 100) begin
            wr_en_i   = (cnt == 5) ? 2'b01 : 2'b00;
            wr_addr_i = {5'd0, 5'd2};
            wr_data_i = {32'h0, 32'hAAAAAAAA};
            #1;
            chk("clr_rd_bp", rd_bp[31:0], 32'h0);
            chk("clr_rd_nb", rd_nb[31:0], 32'h0);
            chk("clr_ready", 32'(ready_bp), 32'h0);
            tick();
            cnt++;
        end
        wr_en_i = 2'b00;
        chk("clr_len", 32'(cnt), 32'd31);
        chk_all_zero("clr_zero");

        // 6: reset mid-clear, then a clear_i during CLEAR is ignored
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_i = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready_bp), 32'h0);
        chk("mid_rst_busy", 32'(busy_bp), 32'h1);
        tick();
        rst_i = 1'b0;
        cnt = 0;
        while (!ready_bp && cnt < 100) begin
            clear_i = (cnt == 4);
            tick();
            cnt++;
        end
        clear_i = 1'b0;
        chk("rst_clr_len", 32'(cnt), 32'd31);
        chk_all_zero("rst_clr_zero");

        wr_en_i   = 2'b10;
        wr_addr_i = {5'd3, 5'd0};
        wr_data_i = {32'h12345678, 32'h0};
        rd_addr_i = {5'd0, 5'd3};
        tick();
        wr_en_i = 2'b00;
        #1;
        chk("post_wr", rd_nb[31:0], 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
